// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory-side and status signals of the shared memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  busy;

  modport master (
    output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport slave (
    input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, data-first with fetch starvation guard
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              drop_q, drop_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              pick_dm;

  // data side wins unless fetch has already waited through STARVE_MAX data grants
  assign pick_dm = bus.dm_req && (!bus.if_req || cnt_q < 4'(STARVE_MAX));

  assign bus.if_gnt    = if_gnt_q;
  assign bus.dm_gnt    = dm_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.busy      = (state_q == ACTIVE);

  // arbitration in IDLE, response routing and fetch-drop tracking in ACTIVE
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if (state_q == IDLE) begin
      if (pick_dm) begin
        state_d     = ACTIVE;
        owner_d     = OWN_DM;
        drop_d      = 1'b0;
        cnt_d       = bus.if_req ? cnt_q + 4'd1 : 4'd0;
        mem_req_d   = 1'b1;
        mem_we_d    = bus.dm_we;
        mem_addr_d  = bus.dm_addr;
        mem_wdata_d = bus.dm_wdata;
        mem_be_d    = bus.dm_be;
        dm_gnt_d    = 1'b1;
      end else if (bus.if_req) begin
        state_d     = ACTIVE;
        owner_d     = OWN_IF;
        drop_d      = 1'b0;
        cnt_d       = 4'd0;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = bus.if_addr;
        mem_wdata_d = '0;
        mem_be_d    = '0;
        if_gnt_d    = 1'b1;
      end
    end else begin
      drop_d = drop_q || (owner_q == OWN_IF && bus.if_flush);
      if (bus.mem_ack) begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
        if (owner_q == OWN_DM) begin
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = mem_we_q ? '0 : bus.mem_rdata;
        end else if (!(drop_q || bus.if_flush)) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.mem_rdata;
        end
      end
    end
  end

  // state and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      drop_q      <= 1'b0;
      cnt_q       <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven and sequence checks of the memory port arbiter with a response scoreboard
module tb_mem_port_arbiter;
  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          delay;
    bit          flush;
    logic [31:0] exp;
  } txn_t;

  typedef struct {
    bit          dm;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  txn_t        tbl[6];
  bit   [31:0] mem[bit [31:0]];
  int          total = 0;
  int          bad = 0;
  int          ack_delay = 0;
  bit          stray_ack = 0;
  int          cnt_m = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] rd(bit [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // memory model: acks after ack_delay wait cycles, applies stores with byte enables
  initial begin
    int wc;
    bit [31:0] cur;
    wc = 0;
    bus.mem_ack = 0;
    bus.mem_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst || bus.mem_ack) begin
        bus.mem_ack = 0;
        wc = 0;
      end else if (stray_ack) begin
        bus.mem_ack = 1;
        bus.mem_rdata = 32'hBAD0BAD0;
        stray_ack = 0;
      end else if (bus.mem_req) begin
        if (wc == ack_delay) begin
          bus.mem_ack = 1;
          if (bus.mem_we) begin
            cur = rd(bus.mem_addr);
            for (int b = 0; b < 4; b++) if (bus.mem_be[b]) cur[8*b+:8] = bus.mem_wdata[8*b+:8];
            mem[bus.mem_addr] = cur;
            bus.mem_rdata = 32'hFFFFFFFF;
          end else bus.mem_rdata = rd(bus.mem_addr);
        end else wc++;
      end
    end
  end

  // response scoreboard and per-cycle handshake invariants
  always @(negedge clk) begin
    if (rst) begin
      exp_t e;
      chk("one_gnt", {31'b0, bus.if_gnt & bus.dm_gnt}, 0);
      chk("if_gnt_rvalid_overlap", {31'b0, bus.if_gnt & bus.if_rvalid}, 0);
      chk("dm_gnt_rvalid_overlap", {31'b0, bus.dm_gnt & bus.dm_rvalid}, 0);
      if (bus.if_rvalid || bus.dm_rvalid) begin
        if (q.size() == 0) chk("unexpected_rvalid", {30'b0, bus.if_rvalid, bus.dm_rvalid}, 0);
        else begin
          e = q.pop_front();
          chk("rvalid_side", {31'b0, bus.dm_rvalid}, {31'b0, e.dm});
          chk("rdata", e.dm ? bus.dm_rdata : bus.if_rdata, e.data);
        end
      end
    end
  end

  task automatic run_txn(txn_t t);
    int n;
    bit got;
    ack_delay = t.delay;
    q.push_back('{t.dm, t.exp});
    if (t.dm) begin
      bus.dm_req = 1;
      bus.dm_we = t.we;
      bus.dm_addr = t.addr;
      bus.dm_wdata = t.wdata;
      bus.dm_be = t.be;
    end else begin
      bus.if_req = 1;
      bus.if_addr = t.addr;
      bus.if_flush = t.flush;
    end
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = t.dm ? bus.dm_gnt : bus.if_gnt;
    end
    bus.if_req = 0;
    bus.dm_req = 0;
    bus.if_flush = 0;
    chk("gnt_latency", n, 1);
    chk("mem_req_at_gnt", {31'b0, bus.mem_req}, 1);
    chk("busy_at_gnt", {31'b0, bus.busy}, 1);
    chk("mem_addr", bus.mem_addr, t.addr);
    chk("mem_we", {31'b0, bus.mem_we}, {31'b0, t.dm & t.we});
    chk("mem_be", {28'b0, bus.mem_be}, t.dm ? {28'b0, t.be} : 32'h0);
    if (t.dm && t.we) chk("mem_wdata", bus.mem_wdata, t.wdata);
    n = 0;
    got = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      got = t.dm ? bus.dm_rvalid : bus.if_rvalid;
    end
    chk("rvalid_latency", n, t.delay + 1);
  endtask

  task automatic contend(int n);
    bit got;
    bit exp_dm;
    bus.if_req = 1;
    bus.if_addr = 32'h100;
    bus.if_flush = 0;
    bus.dm_req = 1;
    bus.dm_we = 0;
    bus.dm_addr = 32'h2000;
    for (int i = 0; i < n; i++) begin
      got = 0;
      exp_dm = (cnt_m < 4);
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        got = bus.if_gnt || bus.dm_gnt;
      end
      chk("contend_gnt_seen", {31'b0, got}, 1);
      chk("contend_order_dm", {31'b0, bus.dm_gnt}, {31'b0, exp_dm});
      q.push_back('{exp_dm, exp_dm ? 32'hDEADBEEF : 32'h00500093});
      cnt_m = exp_dm ? cnt_m + 1 : 0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (q.size() != 0 || bus.busy); k++) @(negedge clk);
    chk("drain_queue", q.size(), 0);
    chk("drain_idle", {31'b0, bus.busy}, 0);
  endtask

  initial begin
    bit got;
    tbl[0] = '{0, 0, 32'h100,  32'h0,        4'h0, 1, 0, 32'h00500093};
    tbl[1] = '{1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0};
    tbl[2] = '{1, 0, 32'h2000, 32'h0,        4'h0, 2, 0, 32'hDEADBEEF};
    tbl[3] = '{1, 1, 32'h2004, 32'h12345678, 4'h3, 1, 0, 32'h0};
    tbl[4] = '{1, 0, 32'h2004, 32'h0,        4'h0, 0, 0, 32'h00005678};
    tbl[5] = '{0, 0, 32'h104,  32'h0,        4'h0, 0, 1, 32'h00a00113};
    mem[32'h100] = 32'h00500093;
    mem[32'h104] = 32'h00a00113;
    mem[32'h108] = 32'h11111111;
    mem[32'h10c] = 32'h22222222;
    bus.if_req = 0;
    bus.if_addr = 0;
    bus.if_flush = 0;
    bus.dm_req = 0;
    bus.dm_we = 0;
    bus.dm_addr = 0;
    bus.dm_wdata = 0;
    bus.dm_be = 0;
    rst = 1;
    #2 rst = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_gnts", {30'b0, bus.if_gnt, bus.dm_gnt}, 0);
    chk("rst_rvalids", {30'b0, bus.if_rvalid, bus.dm_rvalid}, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_we_be", {27'b0, bus.mem_we, bus.mem_be}, 0);
    rst = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_txn(tbl[i]);
    // flush during a fetch with three wait cycles: response dropped, next fetch normal
    ack_delay = 3;
    bus.if_req = 1;
    bus.if_addr = 32'h108;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.if_gnt;
    end
    bus.if_req = 0;
    chk("flush_gnt_seen", {31'b0, got}, 1);
    @(negedge clk);
    bus.if_flush = 1;
    @(negedge clk);
    bus.if_flush = 0;
    chk("flush_busy_held", {31'b0, bus.busy}, 1);
    chk("flush_mem_req_held", {31'b0, bus.mem_req}, 1);
    for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
    chk("flush_busy_drops", {31'b0, bus.busy}, 0);
    run_txn('{0, 0, 32'h10c, 32'h0, 4'h0, 0, 0, 32'h22222222});
    // stray ack in IDLE
    stray_ack = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_busy", {31'b0, bus.busy}, 0);
      chk("stray_mem_req", {31'b0, bus.mem_req}, 0);
      chk("stray_gnts", {30'b0, bus.if_gnt, bus.dm_gnt}, 0);
    end
    // sustained contention: DM x4 then IF, repeating
    ack_delay = 0;
    cnt_m = 0;
    contend(12);
    bus.if_req = 0;
    bus.dm_req = 0;
    drain();
    // reset during an active transaction with the starve counter saturated
    ack_delay = 5;
    contend(2);
    #2 rst = 0;
    bus.if_req = 0;
    bus.dm_req = 0;
    #1;
    chk("midrst_mem_req", {31'b0, bus.mem_req}, 0);
    chk("midrst_busy", {31'b0, bus.busy}, 0);
    chk("midrst_gnts", {30'b0, bus.if_gnt, bus.dm_gnt}, 0);
    q.delete();
    @(negedge clk);
    rst = 1;
    cnt_m = 0;
    ack_delay = 0;
    contend(5);
    bus.if_req = 0;
    bus.dm_req = 0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single shared memory port between the instruction-fetch requester and the data-memory (load/store) requester. The core has split IF and MEM stages but only one physical memory port, and this block sits between them and that port. It grants one transaction at a time and holds the request on the memory side until the memory acknowledges. It then routes the response back to the owning requester. Data accesses win by default; a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 wide)
- STARVE_MAX, 4, consecutive data-side wins tolerated while fetch is waiting (1..15)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  discard any outstanding fetch response
- if_gnt  out  1  one-cycle pulse: fetch request captured
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  store byte enables
- dm_gnt  out  1  one-cycle pulse: data request captured
- dm_rvalid  out  1  one-cycle pulse: load data valid, or store completed
- dm_rdata  out  DATA_W  load data; 0 on store completion
- mem_req  out  1  memory request; held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_be  out  —  registered copy of the granted request (mem_we=0 and mem_be=0 for fetch)
- mem_ack  in  1  memory done; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction outstanding (state != IDLE)

## Operation
- States:
  - IDLE: no transaction outstanding.
  - ACTIVE: mem_req high, waiting for mem_ack.
- Owner register: owner ∈ {IF, DM}; drop flag for fetch.
- Arbitration, evaluated in IDLE only:
  - Both requesting and starve_cnt < STARVE_MAX: DM wins.
  - Both requesting and starve_cnt == STARVE_MAX: IF wins.
  - Single requester: that requester wins.
  - No request: stay in IDLE.
- Starve counter update at each grant:
  - DM granted while if_req=1: cnt+1, saturating at STARVE_MAX.
  - IF granted: cnt=0.
  - DM granted while if_req=0: cnt=0.
- On grant:
  - Latch request fields into the mem_* registers and set owner.
  - Pulse the winner's gnt for one cycle.
  - Go to ACTIVE.
- In ACTIVE:
  - mem_* are held stable.
  - Requester inputs are ignored, including new reqs; they wait.
- On mem_ack in ACTIVE:
  - Capture mem_rdata.
  - Pulse the owner's rvalid.
  - Return to IDLE.
  - For a DM store, dm_rdata=0.
- if_flush:
  - Asserted while owner=IF in ACTIVE, or in the same cycle as mem_ack with owner=IF: the drop flag is set and the response's if_rvalid is suppressed.
  - The memory transaction still completes; mem_req is never withdrawn.
  - if_flush in IDLE has no effect. A same-cycle if_req is still arbitrated normally.
- mem_ack outside ACTIVE is ignored.
- Reset (asynchronous, any time, including mid-transaction):
  - State=IDLE, owner=IF, drop=0, starve_cnt=0.
  - mem_req and all mem_* = 0; all gnt/rvalid = 0; if_rdata and dm_rdata = 0; busy=0.

## Timing
- All outputs are registered; no combinational path from an input to any output.
- Request seen in IDLE at cycle N:
  - gnt and mem_req high from cycle N+1.
  - Fastest completion: mem_ack at N+1, rvalid at N+2.
  - State is back in IDLE at N+2, so a new grant shows at N+3.
- Throughput: at most one transaction per 2 cycles; single outstanding.
- mem_ack with k wait cycles after mem_req rises gives rvalid at N+2+k.
- gnt and rvalid for the same requester never overlap in the same cycle.
- At most one gnt is high per cycle.

## Test plan
- Single fetch:
  - Stimulus: if_req, if_addr=0x100; mem_ack one cycle after mem_req with mem_rdata=0x00500093.
  - Required response: if_gnt at N+1; mem_addr=0x100, mem_we=0; if_rvalid at N+3 with if_rdata=0x00500093; busy high N+1..N+2.
- Store then load:
  - Stimulus: dm_req, dm_we=1, addr=0x2000, wdata=0xDEADBEEF, be=0xF; then a load from 0x2000; the memory model returns 0xDEADBEEF.
  - Required response: store dm_rvalid with dm_rdata=0; load dm_rvalid with dm_rdata=0xDEADBEEF.
- Contention with starvation, STARVE_MAX=4:
  - Stimulus: if_req and dm_req held high continuously.
  - Required response: grant order DM,DM,DM,DM,IF,DM,…
- Flush:
  - Stimulus: fetch granted, mem_ack delayed 3 cycles, if_flush pulsed in the 2nd wait cycle.
  - Required response: no if_rvalid; busy drops after mem_ack; the next fetch completes normally.
- Reset mid-transaction:
  - Stimulus: rst low asynchronously during ACTIVE.
  - Required response: mem_req=0 and busy=0 immediately; after release, a fresh request is arbitrated with starve_cnt=0.
- Stray ack:
  - Stimulus: mem_ack pulsed in IDLE.
  - Required response: no rvalid on either side; no state change.
